// File: rtl/pio_cmd_sequencer_if.sv
// pio_cmd_sequencer_if: command/completion channel between the PIO command
// sequencer (master) and the edge-detector datapath (slave).
// Carries the valid/ready command handshake and the done/error/result return path.
interface pio_cmd_sequencer_if #(
  parameter int OPC_W = 4,
  parameter int PAY_W = 27,
  parameter int RES_W = 24
);
  logic             dp_valid;
  logic [OPC_W-1:0] dp_opcode;
  logic [PAY_W-1:0] dp_payload;
  logic             dp_ready;
  logic             dp_done;
  logic             dp_error;
  logic [RES_W-1:0] dp_result;

  modport master (
    output dp_valid, dp_opcode, dp_payload,
    input  dp_ready, dp_done, dp_error, dp_result
  );

  modport slave (
    input  dp_valid, dp_opcode, dp_payload,
    output dp_ready, dp_done, dp_error, dp_result
  );
endinterface

// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer: runs a 4-phase REQ/ACK handshake with the HPS command PIO,
// issues each command to the datapath over valid/ready, waits for done and
// publishes a status word {ACK, BUSY, ERR, TIMEOUT, 0..., result}.
// Optional feature: define PIO_CTRL_WATCHDOG_EN to abort commands that do not
// complete within TIMEOUT_CYCLES clocks (sets ERR and TIMEOUT).
module pio_cmd_sequencer #(
  parameter int OPC_W          = 4,
  parameter int PAY_W          = 27,
  parameter int RES_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cmd_word,
  pio_cmd_sequencer_if.master dp,
  output logic [31:0]         status_word
);

  // Elaboration-time sanity check of the command/status word layout.
  if (OPC_W + PAY_W != 31 || RES_W > 28 || RES_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pio_cmd_sequencer: inconsistent OPC_W/PAY_W/RES_W/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

  state_t             state_reg, state_next;
  logic               dp_valid_reg, dp_valid_next;
  logic [OPC_W-1:0]   opcode_reg, opcode_next;
  logic [PAY_W-1:0]   payload_reg, payload_next;
  logic [RES_W-1:0]   result_reg, result_next;
  logic               ack_reg, ack_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;
  logic               timeout_reg, timeout_next;
  logic               armed_reg, armed_next;
  logic               do_complete, do_timeout;
  logic               wd_expired;

  logic               req;
  logic [OPC_W-1:0]   cmd_opcode;
  logic [PAY_W-1:0]   cmd_payload;

  assign req         = cmd_word[31];
  assign cmd_opcode  = cmd_word[30 -: OPC_W];
  assign cmd_payload = cmd_word[PAY_W-1:0];

`ifdef PIO_CTRL_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;

  // Expiry on the TIMEOUT_CYCLES-th clock spent in ISSUE/WAIT_DONE.
  assign wd_expired = (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: held at zero in IDLE, counts while a command is outstanding.
  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    if (state_reg == IDLE) begin
      wd_cnt_next = '0;
    end else if (state_reg == ISSUE || state_reg == WAIT_DONE) begin
      wd_cnt_next = wd_cnt_reg + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) wd_cnt_reg <= '0;
    else       wd_cnt_reg <= wd_cnt_next;
  end
`else
  // Without the watchdog the FSM waits indefinitely for completion.
  assign wd_expired = 1'b0;
`endif

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_next    = state_reg;
    dp_valid_next = dp_valid_reg;
    opcode_next   = opcode_reg;
    payload_next  = payload_reg;
    result_next   = result_reg;
    ack_next      = ack_reg;
    busy_next     = busy_reg;
    err_next      = err_reg;
    timeout_next  = timeout_reg;
    armed_next    = armed_reg;
    do_complete   = 1'b0;
    do_timeout    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req && armed_reg) begin
          opcode_next  = cmd_opcode;
          payload_next = cmd_payload;
          err_next     = 1'b0;
          timeout_next = 1'b0;
          armed_next   = 1'b0;
          if (cmd_opcode == '0) begin
            // NOP acknowledges straight away and leaves the result untouched.
            state_next = ACK;
            ack_next   = 1'b1;
          end else begin
            state_next    = ISSUE;
            dp_valid_next = 1'b1;
            busy_next     = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Completion in the acceptance cycle beats a simultaneous watchdog expiry.
        if (dp_valid_reg && dp.dp_ready && dp.dp_done) begin
          do_complete = 1'b1;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
        end else if (dp_valid_reg && dp.dp_ready) begin
          dp_valid_next = 1'b0;
          state_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (dp.dp_done)      do_complete = 1'b1;
        else if (wd_expired) do_timeout  = 1'b1;
      end
      ACK: begin
        // Re-arm only once REQ has been seen low, so a held REQ is not re-issued.
        if (!req) begin
          state_next = IDLE;
          ack_next   = 1'b0;
          armed_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_complete) begin
      state_next    = ACK;
      dp_valid_next = 1'b0;
      busy_next     = 1'b0;
      ack_next      = 1'b1;
      result_next   = dp.dp_result;
      err_next      = dp.dp_error;
    end

    if (do_timeout) begin
      state_next    = ACK;
      dp_valid_next = 1'b0;
      busy_next     = 1'b0;
      ack_next      = 1'b1;
      err_next      = 1'b1;
      timeout_next  = 1'b1;
    end
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      dp_valid_reg <= 1'b0;
      opcode_reg   <= '0;
      payload_reg  <= '0;
      result_reg   <= '0;
      ack_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
      armed_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      dp_valid_reg <= dp_valid_next;
      opcode_reg   <= opcode_next;
      payload_reg  <= payload_next;
      result_reg   <= result_next;
      ack_reg      <= ack_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      timeout_reg  <= timeout_next;
      armed_reg    <= armed_next;
    end
  end

  assign dp.dp_valid   = dp_valid_reg;
  assign dp.dp_opcode  = opcode_reg;
  assign dp.dp_payload = payload_reg;

  // Status word assembly from registered fields; unused bits read as zero.
  always_comb begin
    status_word              = '0;
    status_word[31]          = ack_reg;
    status_word[30]          = busy_reg;
    status_word[29]          = err_reg;
    status_word[28]          = timeout_reg;
    status_word[RES_W-1:0]   = result_reg;
  end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// tb_pio_cmd_sequencer: directed bench for pio_cmd_sequencer. Expected datapath
// commands and expected status words at each ACK rise are queued when stimulus
// is driven and checked by a monitor when the DUT produces them; directed
// checks cover reset, hold/stability, NOP, error, held REQ, early REQ drop,
// watchdog (when PIO_CTRL_WATCHDOG_EN is defined) and reset mid-command.
module tb_pio_cmd_sequencer;
  localparam int OPC_W = 4;
  localparam int PAY_W = 27;
  localparam int RES_W = 24;
  localparam int TO    = 16;

  typedef struct packed {
    logic [OPC_W-1:0] op;
    logic [PAY_W-1:0] pay;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_word;
  logic [31:0] status_word;

  int errors = 0;
  int checks = 0;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_stat_q[$];

  pio_cmd_sequencer_if #(.OPC_W(OPC_W), .PAY_W(PAY_W), .RES_W(RES_W)) dp_if ();

  pio_cmd_sequencer #(
    .OPC_W(OPC_W), .PAY_W(PAY_W), .RES_W(RES_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_word(cmd_word),
    .dp(dp_if),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic req, input logic [OPC_W-1:0] op,
                                     input logic [PAY_W-1:0] pay);
    return {req, op, pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [OPC_W-1:0] op, input logic [PAY_W-1:0] pay);
    cmd_t c;
    c.op  = op;
    c.pay = pay;
    exp_cmd_q.push_back(c);
  endtask

  // Monitor: pops the scoreboard on each accepted command and each ACK rise.
  logic ack_prev = 1'b0;
  cmd_t mon_c;
  logic [31:0] mon_s;
  always @(negedge clk) begin
    if (reset) begin
      ack_prev <= 1'b0;
    end else begin
      if (dp_if.dp_valid && dp_if.dp_ready) begin
        chk("cmd_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
        if (exp_cmd_q.size() != 0) begin
          mon_c = exp_cmd_q.pop_front();
          chk("cmd_opcode", 32'(dp_if.dp_opcode), 32'(mon_c.op));
          chk("cmd_payload", 32'(dp_if.dp_payload), 32'(mon_c.pay));
          $display("cmd accepted: opcode=%0d payload=0x%07h", dp_if.dp_opcode, dp_if.dp_payload);
        end
      end
      if (status_word[31] && !ack_prev) begin
        chk("ack_expected", 32'(exp_stat_q.size() != 0), 32'd1);
        if (exp_stat_q.size() != 0) begin
          mon_s = exp_stat_q.pop_front();
          chk("ack_status", status_word, mon_s);
          $display("ack: status=0x%08h", status_word);
        end
      end
      ack_prev <= status_word[31];
    end
  end

  initial begin
    reset               = 1'b1;
    cmd_word            = '0;
    dp_if.dp_ready      = 1'b0;
    dp_if.dp_done       = 1'b0;
    dp_if.dp_error      = 1'b0;
    dp_if.dp_result     = '0;
    tick(); tick(); tick();
    chk("rst_status", status_word, 32'h0);
    chk("rst_valid", 32'(dp_if.dp_valid), 32'd0);
    chk("rst_opcode", 32'(dp_if.dp_opcode), 32'd0);
    chk("rst_payload", 32'(dp_if.dp_payload), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_status", status_word, 32'h0);

    // 1: basic command, ready immediately, done three cycles later.
    cmd_word       = mk(1'b1, 4'd1, 27'h55);
    dp_if.dp_ready = 1'b1;
    push_cmd(4'd1, 27'h55);
    exp_stat_q.push_back(32'h80AB_CDEF);
    tick();
    chk("t1_valid", 32'(dp_if.dp_valid), 32'd1);
    chk("t1_busy", status_word, 32'h4000_0000);
    tick();
    chk("t1_valid_drop", 32'(dp_if.dp_valid), 32'd0);
    cmd_word = mk(1'b1, 4'd9, 27'h77);  // ignored while busy
    tick(); tick();
    chk("t1_payload_hold", 32'(dp_if.dp_payload), 32'h55);
    dp_if.dp_done   = 1'b1;
    dp_if.dp_result = 24'hAB_CDEF;
    tick();
    dp_if.dp_done = 1'b0;
    chk("t1_ack", status_word, 32'h80AB_CDEF);
    cmd_word = '0;
    tick();
    chk("t1_release", status_word, 32'h00AB_CDEF);

    // 2: ready held low five cycles; command must stay stable.
    dp_if.dp_ready = 1'b0;
    cmd_word       = mk(1'b1, 4'd5, 27'h123);
    push_cmd(4'd5, 27'h123);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(dp_if.dp_valid), 32'd1);
      chk("t2_opcode", 32'(dp_if.dp_opcode), 32'd5);
      chk("t2_payload", 32'(dp_if.dp_payload), 32'h123);
      chk("t2_busy", status_word, 32'h40AB_CDEF);
      tick();
    end
    dp_if.dp_ready = 1'b1;
    chk("t2_valid6", 32'(dp_if.dp_valid), 32'd1);
    tick();
    chk("t2_valid_drop", 32'(dp_if.dp_valid), 32'd0);
    chk("t2_wait_busy", status_word, 32'h40AB_CDEF);
    dp_if.dp_done   = 1'b1;
    dp_if.dp_result = 24'h12_3456;
    exp_stat_q.push_back(32'h8012_3456);
    tick();
    dp_if.dp_done = 1'b0;
    chk("t2_ack", status_word, 32'h8012_3456);
    cmd_word = '0;
    tick();
    chk("t2_release", status_word, 32'h0012_3456);

    // 3: NOP acknowledges without issuing, result unchanged.
    cmd_word = mk(1'b1, 4'd0, 27'h777);
    exp_stat_q.push_back(32'h8012_3456);
    tick();
    chk("t3_no_valid", 32'(dp_if.dp_valid), 32'd0);
    chk("t3_ack", status_word, 32'h8012_3456);
    cmd_word = '0;
    tick();
    chk("t3_release", status_word, 32'h0012_3456);

    // 4: error completion, then cleared by the next acceptance.
    cmd_word = mk(1'b1, 4'd3, 27'h1);
    push_cmd(4'd3, 27'h1);
    tick(); tick();
    dp_if.dp_done   = 1'b1;
    dp_if.dp_error  = 1'b1;
    dp_if.dp_result = 24'h00_00AA;
    exp_stat_q.push_back(32'hA000_00AA);
    tick();
    dp_if.dp_done  = 1'b0;
    dp_if.dp_error = 1'b0;
    chk("t4_err_ack", status_word, 32'hA000_00AA);
    cmd_word = '0;
    tick();
    chk("t4_err_persist", status_word, 32'h2000_00AA);
    cmd_word = mk(1'b1, 4'd2, 27'h2);
    push_cmd(4'd2, 27'h2);
    tick();
    chk("t4_err_cleared", status_word, 32'h4000_00AA);
    // done in the same cycle as the handshake completes at once
    dp_if.dp_done   = 1'b1;
    dp_if.dp_result = 24'h5A_5A5A;
    exp_stat_q.push_back(32'h805A_5A5A);
    tick();
    dp_if.dp_done = 1'b0;
    chk("t4_same_cycle", status_word, 32'h805A_5A5A);
    chk("t4_same_valid", 32'(dp_if.dp_valid), 32'd0);

    // 5: REQ held high after ACK must not start another command.
    for (int i = 0; i < 5; i++) begin
      cmd_word = mk(1'b1, 4'd2, 27'(i + 16));
      tick();
      chk("t5_hold_ack", status_word, 32'h805A_5A5A);
      chk("t5_no_valid", 32'(dp_if.dp_valid), 32'd0);
    end
    cmd_word = '0;
    tick();
    chk("t5_release", status_word, 32'h005A_5A5A);

    // Early REQ drop: no abort, ACK lasts exactly one cycle.
    dp_if.dp_ready = 1'b0;
    cmd_word       = mk(1'b1, 4'd4, 27'h9);
    push_cmd(4'd4, 27'h9);
    tick();
    cmd_word = '0;
    tick(); tick();
    chk("early_valid", 32'(dp_if.dp_valid), 32'd1);
    chk("early_busy", status_word, 32'h405A_5A5A);
    dp_if.dp_ready = 1'b1;
    tick();
    dp_if.dp_ready  = 1'b0;
    dp_if.dp_done   = 1'b1;
    dp_if.dp_result = 24'h11_1111;
    exp_stat_q.push_back(32'h8011_1111);
    tick();
    dp_if.dp_done = 1'b0;
    chk("early_ack", status_word, 32'h8011_1111);
    tick();
    chk("early_ack_1cyc", status_word, 32'h0011_1111);

`ifdef PIO_CTRL_WATCHDOG_EN
    // 6: watchdog expiry after TO cycles without completion.
    cmd_word = mk(1'b1, 4'd6, 27'h42);
    exp_stat_q.push_back(32'hB011_1111);
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("wd_busy", status_word, 32'h4011_1111);
    end
    tick();
    chk("wd_timeout", status_word, 32'hB011_1111);
    chk("wd_valid", 32'(dp_if.dp_valid), 32'd0);
    dp_if.dp_done   = 1'b1;
    dp_if.dp_result = 24'hFF_FFFF;
    tick();
    dp_if.dp_done = 1'b0;
    chk("wd_late_done", status_word, 32'hB011_1111);
    cmd_word = '0;
    tick();
    chk("wd_release", status_word, 32'h3011_1111);
    cmd_word       = mk(1'b1, 4'd7, 27'h3);
    dp_if.dp_ready = 1'b1;
    push_cmd(4'd7, 27'h3);
    tick();
    chk("wd_cleared", status_word, 32'h4011_1111);
    tick();
`else
    // Without the watchdog the command waits indefinitely.
    cmd_word = mk(1'b1, 4'd6, 27'h42);
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("nowd_busy", status_word, 32'h4011_1111);
    end
    push_cmd(4'd6, 27'h42);
    dp_if.dp_ready = 1'b1;
    tick();
    chk("nowd_wait", status_word, 32'h4011_1111);
`endif

    // Reset while in WAIT_DONE clears everything.
    dp_if.dp_ready = 1'b0;
    cmd_word       = '0;
    reset          = 1'b1;
    tick();
    chk("rst_wait_status", status_word, 32'h0);
    chk("rst_wait_valid", 32'(dp_if.dp_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_wait_idle", status_word, 32'h0);

    // Reset while in ISSUE drops dp_valid on the next edge.
    cmd_word = mk(1'b1, 4'd8, 27'h4);
    tick();
    chk("rst_issue_valid", 32'(dp_if.dp_valid), 32'd1);
    chk("rst_issue_op", 32'(dp_if.dp_opcode), 32'd8);
    reset    = 1'b1;
    cmd_word = '0;
    tick();
    chk("rst_issue_drop", 32'(dp_if.dp_valid), 32'd0);
    chk("rst_issue_opclr", 32'(dp_if.dp_opcode), 32'd0);
    chk("rst_issue_status", status_word, 32'h0);
    reset = 1'b0;
    tick(); tick();

    chk("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("stat_q_drained", 32'(exp_stat_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
